log_mem_ctrl: RTL and testbench
===============================

Name: log_mem_ctrl

Overview:
Scheduler for the single-port FIR log RAM. Two requesters share the RAM:
- the FIR output logger, which writes samples sequentially from address 0;
- the readout path, which replays the stored samples in order on a run request.

The block owns the RAM address, write-enable and write-data lines. It tracks the fill level and signals run completion back to the host-side control.

Parameters:
ADDR_W, 10, RAM address width; depth DEPTH = 2**ADDR_W
DATA_W, 16, sample and RAM word width

Ports:
clock  in  1  system clock, all logic on posedge
i_reset  in  1  synchronous, active-high reset
i_log_en  in  1  level; logging permitted while high
i_sample_valid  in  1  qualifies i_sample for one cycle
i_sample  in  DATA_W  FIR output sample
i_run  in  1  single-cycle pulse; request readout of the stored samples
o_ram_we  out  1  RAM write enable
o_ram_addr  out  ADDR_W  RAM address (read and write)
o_ram_wdata  out  DATA_W  RAM write data
i_ram_rdata  in  DATA_W  RAM read data, 1-cycle latency after the address
o_rd_valid  out  1  o_rd_data holds a replayed sample
o_rd_data  out  DATA_W  replayed sample
o_count  out  ADDR_W+1  number of stored samples, 0..DEPTH
o_full  out  1  o_count == DEPTH
o_busy  out  1  state is not IDLE
o_run_complete  out  1  single-cycle pulse when readout finishes

Behaviour:
- Reset: state IDLE; count=0; rd_ptr=0. All outputs are 0: we, addr, wdata, rd_valid, rd_data, full, busy, run_complete. Reset mid-operation aborts immediately and discards the stored contents (count=0).
- States (2-bit): IDLE=00, LOG=01, READ=10, FLUSH=11. Any illegal encoding goes to IDLE.
- IDLE:
  - if i_run -> READ; run has priority over logging;
  - else if i_log_en and !o_full -> LOG.
- LOG:
  - o_ram_we = i_sample_valid & !o_full (combinational);
  - o_ram_addr = count[ADDR_W-1:0]; o_ram_wdata = i_sample;
  - count increments on each write.
  - Exits to IDLE when: i_log_en=0; or the write that makes count=DEPTH (full; further samples dropped); or i_run=1.
  - A sample valid in the same cycle as i_run is still written. The i_run is then latched as run_pend and served from IDLE on the next cycle.
- READ:
  - o_ram_we=0; o_ram_addr=rd_ptr; rd_ptr increments every cycle.
  - When rd_ptr == count-1 is issued -> FLUSH.
  - If count==0 on entry: no reads; go directly to FLUSH.
- FLUSH: one cycle to collect the last read data, then -> IDLE.
- Read data timing: o_rd_valid and o_rd_data are registered. o_rd_data = i_ram_rdata and o_rd_valid=1 in the cycle after each address issued in READ. A readout of N samples therefore gives N consecutive valid cycles, starting 2 cycles after i_run.
- o_run_complete pulses in the FLUSH cycle. This is coincident with the last o_rd_valid, or alone when count==0.
- Readout is read-and-clear: on leaving FLUSH, count=0, o_full=0 and rd_ptr=0.
- i_run while in READ or FLUSH is ignored; it is not queued.
- i_sample_valid outside LOG is dropped silently.
- o_count and o_full are registered, and updated the cycle after each write.
- Counters: count is ADDR_W+1 bits, saturating at DEPTH with no wrap. rd_ptr is ADDR_W bits.

Decomposition:
- Shared package log_mem_pkg: state encodings ST_IDLE, ST_LOG, ST_READ, ST_FLUSH, plus the default ADDR_W/DATA_W constants.
- One sub-module log_addr_cnt (parameter W; synchronous rst, en, load-zero; output value). Instantiated twice: once for the write count (W=ADDR_W+1) and once for rd_ptr (W=ADDR_W).
- FSM and read-data register remain in the top.

Test Plan (ADDR_W=3, DEPTH=8):
- Log 5 samples 0x11..0x15 with i_log_en=1 -> writes to addresses 0..4; o_count=5; o_full=0. Then i_run -> o_rd_valid high 5 cycles with 0x11..0x15, o_run_complete on the 5th, then o_count=0.
- Log 10 samples with i_log_en held -> exactly 8 writes, o_full=1, state returns to IDLE. Samples 9-10 are dropped, and i_log_en is ignored until readout.
- i_run with count=0 -> no o_rd_valid; o_run_complete pulses 2 cycles after i_run; o_busy high for 2 cycles.
- i_run coincident with i_sample_valid in LOG (3 stored) -> 4th sample written; readout returns 4 samples.
- Drop i_log_en after 2 samples, reassert, log 2 more -> addresses 0..3 are used contiguously; o_count=4.
- Assert i_reset during READ at the 3rd address -> next cycle all outputs 0, o_count=0, state IDLE; no o_run_complete.

Source files
------------

// File: rtl/log_mem_pkg.sv
// Shared definitions for the FIR log RAM scheduler: FSM state encodings
// and the default RAM geometry.
package log_mem_pkg;

  localparam int LOG_ADDR_W = 10;
  localparam int LOG_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOG   = 2'b01,
    ST_READ  = 2'b10,
    ST_FLUSH = 2'b11
  } state_e;

endpackage

// File: rtl/log_addr_cnt.sv
// Up-counter used for both the fill level and the readout pointer.
// Clear wins over enable; the count holds at MAX instead of wrapping.
module log_addr_cnt
  import log_mem_pkg::*;
#(
  parameter int           W   = 4,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clock,
  input  logic         i_reset,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] value_o
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = '0;
    end else if (en_i && (value_q != MAX)) begin
      value_d = value_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/log_mem_ctrl.sv
// Scheduler for the single-port FIR log RAM. The logger fills the RAM from
// address 0; a run request replays the stored samples in order and then
// empties the log (read-and-clear).
module log_mem_ctrl
  import log_mem_pkg::*;
#(
  parameter int ADDR_W = LOG_ADDR_W,
  parameter int DATA_W = LOG_DATA_W
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_log_en,
  input  logic              i_sample_valid,
  input  logic [DATA_W-1:0] i_sample,
  input  logic              i_run,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_busy,
  output logic              o_run_complete
);

  localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e state_q;
  state_e state_d;
  logic   run_pend_q;
  logic   run_pend_d;
  logic   rd_valid_q;

  logic [ADDR_W:0]   count_w;
  logic [ADDR_W-1:0] rd_ptr_w;
  logic              full;
  logic              log_we;
  logic              read_issue;
  logic              last_issue;
  logic              clr_all;

  assign full       = (count_w == DEPTH_V);
  assign log_we     = (state_q == ST_LOG) && i_sample_valid && !full;
  assign read_issue = (state_q == ST_READ) && (count_w != '0);
  // count==0 gives count-1 = all ones, which a zero-extended pointer never matches.
  assign last_issue = (state_q == ST_READ) && ({1'b0, rd_ptr_w} == (count_w - CNT_ONE));
  assign clr_all    = (state_q == ST_FLUSH);

  // Fill level: one step per accepted write, emptied when a readout finishes.
  log_addr_cnt #(
    .W   (ADDR_W + 1),
    .MAX (DEPTH_V)
  ) u_wr_cnt (
    .clock   (clock),
    .i_reset (i_reset),
    .en_i    (log_we),
    .clr_i   (clr_all),
    .value_o (count_w)
  );

  // Readout pointer: advances on every address issued in READ.
  log_addr_cnt #(
    .W (ADDR_W)
  ) u_rd_ptr (
    .clock   (clock),
    .i_reset (i_reset),
    .en_i    (read_issue),
    .clr_i   (clr_all),
    .value_o (rd_ptr_w)
  );

  // State and pending-run registers.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      run_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_pend_q <= run_pend_d;
    end
  end

  // Next-state logic; a run seen while logging is parked in run_pend and
  // picked up from IDLE, which always services it immediately.
  always_comb begin
    state_d    = state_q;
    run_pend_d = run_pend_q;
    case (state_q)
      ST_IDLE: begin
        run_pend_d = 1'b0;
        if (i_run || run_pend_q) begin
          state_d = ST_READ;
        end else if (i_log_en && !full) begin
          state_d = ST_LOG;
        end
      end
      ST_LOG: begin
        if (i_run) begin
          run_pend_d = 1'b1;
        end
        if (i_run || !i_log_en || (log_we && (count_w == (DEPTH_V - CNT_ONE)))) begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if ((count_w == '0) || last_issue) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // RAM port and status outputs decoded from the current state.
  always_comb begin
    o_ram_we       = log_we;
    o_ram_addr     = '0;
    o_ram_wdata    = '0;
    o_busy         = (state_q != ST_IDLE);
    o_run_complete = (state_q == ST_FLUSH);
    case (state_q)
      ST_LOG: begin
        o_ram_addr  = count_w[ADDR_W-1:0];
        o_ram_wdata = i_sample;
      end
      ST_READ: o_ram_addr = rd_ptr_w;
      default: o_ram_addr = '0;
    endcase
  end

  // Read-valid register: one cycle behind each issued address, which lines
  // it up with the RAM's own output register.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= read_issue;
    end
  end

  // The RAM output register already holds the sample; mask it outside valid.
  assign o_rd_valid = rd_valid_q;
  assign o_rd_data  = rd_valid_q ? i_ram_rdata : '0;
  assign o_count    = count_w;
  assign o_full     = full;

endmodule

// File: tb/tb_log_mem_ctrl.sv
// Randomized bench for log_mem_ctrl with ADDR_W=3. The reference model is a
// queue of the samples the log should hold; the RAM is a simple array with
// a registered read port.
module tb_log_mem_ctrl;

  localparam int AW    = 3;
  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic          clock;
  logic          i_reset;
  logic          i_log_en;
  logic          i_sample_valid;
  logic [DW-1:0] i_sample;
  logic          i_run;
  logic          o_ram_we;
  logic [AW-1:0] o_ram_addr;
  logic [DW-1:0] o_ram_wdata;
  logic [DW-1:0] i_ram_rdata;
  logic          o_rd_valid;
  logic [DW-1:0] o_rd_data;
  logic [AW:0]   o_count;
  logic          o_full;
  logic          o_busy;
  logic          o_run_complete;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] ram_mem [DEPTH];

  log_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock          (clock),
    .i_reset        (i_reset),
    .i_log_en       (i_log_en),
    .i_sample_valid (i_sample_valid),
    .i_sample       (i_sample),
    .i_run          (i_run),
    .o_ram_we       (o_ram_we),
    .o_ram_addr     (o_ram_addr),
    .o_ram_wdata    (o_ram_wdata),
    .i_ram_rdata    (i_ram_rdata),
    .o_rd_valid     (o_rd_valid),
    .o_rd_data      (o_rd_data),
    .o_count        (o_count),
    .o_full         (o_full),
    .o_busy         (o_busy),
    .o_run_complete (o_run_complete)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port RAM with one cycle of read latency.
  always @(posedge clock) begin
    if (o_ram_we) ram_mem[o_ram_addr] <= o_ram_wdata;
    i_ram_rdata <= ram_mem[o_ram_addr];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Enter logging, offer n samples (optionally with idle gaps), then drop log_en.
  task automatic log_burst(input int n, input bit seq, input logic [DW-1:0] first, input bit gaps);
    int g;
    logic exp_we;
    i_log_en = 1'b1;
    i_sample_valid = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      i_sample_valid = 1'b0;
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      for (int j = 0; j < g; j++) begin
        #1;
        total++;
        if (o_ram_we !== 1'b0) begin
          bad++;
          $display("FAIL gap_we got=%0b want=0", o_ram_we);
        end
        tick();
      end
      i_sample = seq ? (first + DW'(i)) : DW'($urandom);
      i_sample_valid = 1'b1;
      #1;
      exp_we = (exp_q.size() < DEPTH);
      total++;
      if (o_ram_we !== exp_we || o_busy !== exp_we) begin
        bad++;
        $display("FAIL log_we_busy got=%0b/%0b want=%0b/%0b", o_ram_we, o_busy, exp_we, exp_we);
      end
      if (exp_we) begin
        total++;
        if (o_ram_addr !== AW'(exp_q.size()) || o_ram_wdata !== i_sample) begin
          bad++;
          $display("FAIL log_addr_data got=%0d/%h want=%0d/%h", o_ram_addr, o_ram_wdata, exp_q.size(), i_sample);
        end
      end
      tick();
      if (exp_we) exp_q.push_back(i_sample);
      total++;
      if (o_count !== (AW+1)'(exp_q.size()) || o_full !== (exp_q.size() == DEPTH)) begin
        bad++;
        $display("FAIL log_count_full got=%0d/%0b want=%0d/%0b", o_count, o_full, exp_q.size(), exp_q.size() == DEPTH);
      end
    end
    i_sample_valid = 1'b0;
    i_log_en = 1'b0;
    tick();
    #1;
    total++;
    if (o_busy !== 1'b0 || o_count !== (AW+1)'(exp_q.size())) begin
      bad++;
      $display("FAIL log_exit got busy=%0b count=%0d want busy=0 count=%0d", o_busy, o_count, exp_q.size());
    end
  endtask

  // Replay the log; pulse=0 means a run is already pending from LOG.
  // noise injects an ignored i_run during READ and stray sample valids.
  task automatic readout(input bit pulse, input bit noise);
    int n;
    int flush_k;
    logic exp_valid;
    n = exp_q.size();
    flush_k = (n == 0) ? 2 : n + 1;
    i_run = pulse;
    i_sample_valid = noise;
    i_sample = DW'($urandom);
    #1;
    total++;
    if (o_busy !== 1'b0 || o_run_complete !== 1'b0) begin
      bad++;
      $display("FAIL run_k0 got busy=%0b done=%0b want 0/0", o_busy, o_run_complete);
    end
    tick();
    for (int k = 1; k <= flush_k + 1; k++) begin
      i_run = (k == 1) ? noise : 1'b0;
      #1;
      exp_valid = (n > 0) && (k >= 2) && (k <= n + 1);
      total++;
      if (o_rd_valid !== exp_valid) begin
        bad++;
        $display("FAIL rd_valid k=%0d got=%0b want=%0b", k, o_rd_valid, exp_valid);
      end
      if (exp_valid) begin
        total++;
        if (o_rd_data !== exp_q[k-2]) begin
          bad++;
          $display("FAIL rd_data k=%0d got=%h want=%h", k, o_rd_data, exp_q[k-2]);
        end
      end
      total++;
      if (o_run_complete !== (k == flush_k) || o_busy !== (k <= flush_k) || o_ram_we !== 1'b0) begin
        bad++;
        $display("FAIL run_status k=%0d got done=%0b busy=%0b we=%0b want %0b/%0b/0",
                 k, o_run_complete, o_busy, o_ram_we, k == flush_k, k <= flush_k);
      end
      if (n > 0 && k <= n) begin
        total++;
        if (o_ram_addr !== AW'(k - 1)) begin
          bad++;
          $display("FAIL rd_addr k=%0d got=%0d want=%0d", k, o_ram_addr, k - 1);
        end
      end
      tick();
    end
    #1;
    total++;
    if (o_count !== '0 || o_full !== 1'b0) begin
      bad++;
      $display("FAIL run_clear got count=%0d full=%0b want 0/0", o_count, o_full);
    end
    exp_q.delete();
    i_run = 1'b0;
    i_sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_log_en = 1'b1;
    i_sample_valid = 1'b1;
    i_sample = 16'hABCD;
    i_run = 1'b0;
    tick();
    tick();
    total++;
    if ({o_ram_we, o_ram_addr, o_ram_wdata, o_rd_valid, o_rd_data, o_count, o_full, o_busy, o_run_complete} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got we=%0b addr=%0d wd=%h rv=%0b rd=%h cnt=%0d full=%0b busy=%0b done=%0b want all 0",
               o_ram_we, o_ram_addr, o_ram_wdata, o_rd_valid, o_rd_data, o_count, o_full, o_busy, o_run_complete);
    end
    i_reset = 1'b0;
    i_log_en = 1'b0;
    i_sample_valid = 1'b0;
    i_sample = '0;
    tick();
    exp_q.delete();
  endtask

  task automatic test_basic();
    log_burst(5, 1'b1, 16'h0011, 1'b0);
    readout(1'b1, 1'b0);
  endtask

  task automatic test_full();
    log_burst(10, 1'b1, 16'h0100, 1'b0);
    log_burst(2, 1'b0, '0, 1'b1);
    readout(1'b1, 1'b0);
  endtask

  task automatic test_empty_run();
    readout(1'b1, 1'b1);
  endtask

  task automatic test_run_during_log();
    log_burst(3, 1'b0, '0, 1'b0);
    i_log_en = 1'b1;
    tick();
    i_sample = DW'($urandom);
    i_sample_valid = 1'b1;
    i_run = 1'b1;
    #1;
    total++;
    if (o_ram_we !== 1'b1 || o_ram_addr !== AW'(3) || o_ram_wdata !== i_sample) begin
      bad++;
      $display("FAIL run_log_write got we=%0b addr=%0d wd=%h want 1/3/%h", o_ram_we, o_ram_addr, o_ram_wdata, i_sample);
    end
    tick();
    exp_q.push_back(i_sample);
    i_run = 1'b0;
    i_sample_valid = 1'b0;
    i_log_en = 1'b0;
    readout(1'b0, 1'b0);
  endtask

  task automatic test_log_gap();
    log_burst(2, 1'b0, '0, 1'b1);
    log_burst(2, 1'b0, '0, 1'b1);
    total++;
    if (o_count !== 4'd4) begin
      bad++;
      $display("FAIL gap_count got=%0d want=4", o_count);
    end
    readout(1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_read();
    log_burst(5, 1'b0, '0, 1'b0);
    i_run = 1'b1;
    tick();
    i_run = 1'b0;
    tick();
    tick();
    #1;
    total++;
    if (o_ram_addr !== AW'(2) || o_busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_read_addr got=%0d busy=%0b want 2/1", o_ram_addr, o_busy);
    end
    i_reset = 1'b1;
    tick();
    #1;
    total++;
    if ({o_ram_we, o_ram_addr, o_ram_wdata, o_rd_valid, o_rd_data, o_count, o_full, o_busy, o_run_complete} !== '0) begin
      bad++;
      $display("FAIL mid_read_reset got we=%0b addr=%0d rv=%0b cnt=%0d busy=%0b done=%0b want all 0",
               o_ram_we, o_ram_addr, o_rd_valid, o_count, o_busy, o_run_complete);
    end
    i_reset = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (o_run_complete !== 1'b0 || o_rd_valid !== 1'b0 || o_busy !== 1'b0) begin
        bad++;
        $display("FAIL post_reset k=%0d got done=%0b rv=%0b busy=%0b want 0/0/0", k, o_run_complete, o_rd_valid, o_busy);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      log_burst(int'($urandom_range(0, 10)), 1'b0, '0, 1'b1);
      if ($urandom_range(0, 1) == 1) log_burst(int'($urandom_range(0, 4)), 1'b0, '0, 1'b1);
      readout(1'b1, 1'(($urandom_range(0, 1))));
    end
  endtask

  initial begin
    i_reset = 1'b1;
    i_log_en = 1'b0;
    i_sample_valid = 1'b0;
    i_sample = '0;
    i_run = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_empty_run();
    test_run_during_log();
    test_log_gap();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
